// File: rtl/riscv_trace_pkg.sv
// Shared types for the retire-trace buffer: entry layout, FSM states and capture modes.
package riscv_trace_pkg;

    localparam int TRACE_DW   = 32;
    localparam int TRACE_REGW = 5;

    localparam logic [1:0] MODE_FREE = 2'd0;
    localparam logic [1:0] MODE_STOP = 2'd1;
    localparam logic [1:0] MODE_TRIG = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_POST,
        ST_DONE
    } trace_state_e;

    typedef struct packed {
        logic [TRACE_DW-1:0]   pc;
        logic [TRACE_DW-1:0]   instr;
        logic [TRACE_REGW-1:0] rd;
        logic                  we;
        logic [TRACE_DW-1:0]   wdata;
    } trace_entry_t;

    // Mode 3 is reserved and behaves as free-run.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == MODE_STOP || m == MODE_TRIG) ? m : MODE_FREE;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace entry storage: one write port, one registered read port, read-before-write.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int W     = 32
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem [DEPTH];

    // Storage is deliberately unreset so it maps onto distributed RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem[raddr_i];
        end
    end

endmodule

// File: rtl/pipe_trace_buffer.sv
// Retire-trace buffer: captures one entry per retired instruction into a circular
// buffer under free-run, stop-when-full or PC-trigger modes; read back oldest-first.
module pipe_trace_buffer
    import riscv_trace_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 16,
    parameter int REGW  = 5,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            arm_i,
    input  logic            clear_i,
    input  logic [1:0]      mode_i,
    input  logic [AW-1:0]   post_cnt_i,
    input  logic [DW-1:0]   trig_pc_i,
    input  logic            ret_valid_i,
    input  logic [DW-1:0]   ret_pc_i,
    input  logic [DW-1:0]   ret_instr_i,
    input  logic [REGW-1:0] ret_rd_i,
    input  logic            ret_we_i,
    input  logic [DW-1:0]   ret_wdata_i,
    input  logic            rd_req_i,
    input  logic [AW-1:0]   rd_idx_i,
    output logic            rd_valid_o,
    output logic [DW-1:0]   rd_pc_o,
    output logic [DW-1:0]   rd_instr_o,
    output logic [DW-1:0]   rd_wdata_o,
    output logic [REGW-1:0] rd_rd_o,
    output logic            rd_we_o,
    output logic [AW:0]     count_o,
    output logic            wrapped_o,
    output logic            triggered_o,
    output logic            done_o,
    output trace_state_e    dbg_state_o
);

    // Same field order as trace_entry_t, sized to this instance's widths.
    typedef struct packed {
        logic [DW-1:0]   pc;
        logic [DW-1:0]   instr;
        logic [REGW-1:0] rd;
        logic            we;
        logic [DW-1:0]   wdata;
    } entry_t;

    localparam int          EW   = $bits(entry_t);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

    trace_state_e  state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          wrapped_q, wrapped_d;
    logic          trig_q, trig_d;
    logic [1:0]    mode_q, mode_d;
    logic [AW-1:0] post_len_q, post_len_d;
    logic [AW-1:0] post_ctr_q, post_ctr_d;
    logic [DW-1:0] trig_pc_q, trig_pc_d;
    logic          wr_en;
    logic          arm_ok;

    entry_t        wr_entry;
    entry_t        rd_entry;
    logic [AW-1:0] rd_addr;
    logic          rd_valid_q;
    logic          rd_hit_q;

    assign wr_entry = '{pc: ret_pc_i, instr: ret_instr_i, rd: ret_rd_i,
                        we: ret_we_i, wdata: ret_wdata_i};
    assign arm_ok   = arm_i && (state_q == ST_IDLE || state_q == ST_DONE);

    // Priority: clear, then arm, then retire; a retire alongside an accepted arm is dropped.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        wrapped_d  = wrapped_q;
        trig_d     = trig_q;
        mode_d     = mode_q;
        post_len_d = post_len_q;
        post_ctr_d = post_ctr_q;
        trig_pc_d  = trig_pc_q;
        wr_en      = 1'b0;

        if (clear_i) begin
            state_d    = ST_IDLE;
            wr_ptr_d   = '0;
            count_d    = '0;
            wrapped_d  = 1'b0;
            trig_d     = 1'b0;
            post_ctr_d = '0;
        end else if (arm_ok) begin
            state_d    = ST_CAPTURE;
            wr_ptr_d   = '0;
            count_d    = '0;
            wrapped_d  = 1'b0;
            trig_d     = 1'b0;
            post_ctr_d = '0;
            mode_d     = norm_mode(mode_i);
            post_len_d = post_cnt_i;
            trig_pc_d  = trig_pc_i;
        end else if (ret_valid_i && (state_q == ST_CAPTURE || state_q == ST_POST)) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (count_q == FULL) begin
                wrapped_d = 1'b1;
            end else begin
                count_d = count_q + (AW+1)'(1);
            end

            case (state_q)
                ST_CAPTURE: begin
                    if (mode_q == MODE_STOP && count_q == LAST) begin
                        state_d = ST_DONE;
                    end else if (mode_q == MODE_TRIG && ret_pc_i == trig_pc_q) begin
                        trig_d     = 1'b1;
                        post_ctr_d = post_len_q;
                        state_d    = (post_len_q == '0) ? ST_DONE : ST_POST;
                    end
                end
                ST_POST: begin
                    post_ctr_d = post_ctr_q - AW'(1);
                    if (post_ctr_q == AW'(1)) begin
                        state_d = ST_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            wrapped_q  <= 1'b0;
            trig_q     <= 1'b0;
            mode_q     <= MODE_FREE;
            post_len_q <= '0;
            post_ctr_q <= '0;
            trig_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            wrapped_q  <= wrapped_d;
            trig_q     <= trig_d;
            mode_q     <= mode_d;
            post_len_q <= post_len_d;
            post_ctr_q <= post_ctr_d;
            trig_pc_q  <= trig_pc_d;
        end
    end

    // Read handshake: rd_req_i is always accepted (no ready); rd_valid_o pulses exactly
    // one cycle later with the entry, or all-zero data when rd_idx_i >= count_o.
    assign rd_addr = (wrapped_q ? wr_ptr_q : '0) + rd_idx_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_valid_q <= 1'b0;
            rd_hit_q   <= 1'b0;
        end else begin
            rd_valid_q <= rd_req_i;
            if (rd_req_i) begin
                rd_hit_q <= ({1'b0, rd_idx_i} < count_q);
            end
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (EW)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .re_i    (rd_req_i),
        .raddr_i (rd_addr),
        .rdata_o (rd_entry)
    );

    assign rd_valid_o  = rd_valid_q;
    assign rd_pc_o     = rd_hit_q ? rd_entry.pc    : '0;
    assign rd_instr_o  = rd_hit_q ? rd_entry.instr : '0;
    assign rd_wdata_o  = rd_hit_q ? rd_entry.wdata : '0;
    assign rd_rd_o     = rd_hit_q ? rd_entry.rd    : '0;
    assign rd_we_o     = rd_hit_q & rd_entry.we;
    assign count_o     = count_q;
    assign wrapped_o   = wrapped_q;
    assign triggered_o = trig_q;
    assign done_o      = (state_q == ST_DONE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Bench for pipe_trace_buffer: queue-based trace model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_pipe_trace_buffer;
    import riscv_trace_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arm = 1'b0;
    logic        clear = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [3:0]  post_cnt = 4'd0;
    logic [31:0] trig_pc = 32'd0;
    logic        ret_valid = 1'b0;
    logic [31:0] ret_pc = 32'd0;
    logic [31:0] ret_instr = 32'd0;
    logic [4:0]  ret_rd = 5'd0;
    logic        ret_we = 1'b0;
    logic [31:0] ret_wdata = 32'd0;
    logic        rd_req = 1'b0;
    logic [3:0]  rd_idx = 4'd0;

    logic         rd_valid_o;
    logic [31:0]  rd_pc_o, rd_instr_o, rd_wdata_o;
    logic [4:0]   rd_rd_o;
    logic         rd_we_o;
    logic [4:0]   count_o;
    logic         wrapped_o, triggered_o, done_o;
    trace_state_e dbg_state_o;

    int errors = 0;
    int checks = 0;

    pipe_trace_buffer #(.DW(32), .DEPTH(DEPTH), .REGW(5)) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .arm_i       (arm),
        .clear_i     (clear),
        .mode_i      (mode),
        .post_cnt_i  (post_cnt),
        .trig_pc_i   (trig_pc),
        .ret_valid_i (ret_valid),
        .ret_pc_i    (ret_pc),
        .ret_instr_i (ret_instr),
        .ret_rd_i    (ret_rd),
        .ret_we_i    (ret_we),
        .ret_wdata_i (ret_wdata),
        .rd_req_i    (rd_req),
        .rd_idx_i    (rd_idx),
        .rd_valid_o  (rd_valid_o),
        .rd_pc_o     (rd_pc_o),
        .rd_instr_o  (rd_instr_o),
        .rd_wdata_o  (rd_wdata_o),
        .rd_rd_o     (rd_rd_o),
        .rd_we_o     (rd_we_o),
        .count_o     (count_o),
        .wrapped_o   (wrapped_o),
        .triggered_o (triggered_o),
        .done_o      (done_o),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- scoreboard / model ----------------
    typedef enum {M_IDLE, M_CAP, M_POST, M_DONE} mstate_e;

    trace_entry_t exp_q[$];
    mstate_e      m_st = M_IDLE;
    bit           m_wrapped = 1'b0;
    bit           m_trig = 1'b0;
    int           m_mode = 0;
    int           m_post = 0;
    int           m_left = 0;
    logic [31:0]  m_tpc = 32'd0;
    bit           exp_rdv = 1'b0;
    trace_entry_t exp_rd = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Trace history as a list of retired entries, oldest first, trimmed to DEPTH.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_st = M_IDLE;
                exp_q.delete();
                m_wrapped = 1'b0;
                m_trig = 1'b0;
                exp_rdv = 1'b0;
            end else begin
                exp_rdv = rd_req;
                if (rd_req) begin
                    exp_rd = (int'(rd_idx) < exp_q.size()) ? exp_q[rd_idx] : '0;
                end
                if (clear) begin
                    m_st = M_IDLE;
                    exp_q.delete();
                    m_wrapped = 1'b0;
                    m_trig = 1'b0;
                end else if (arm && (m_st == M_IDLE || m_st == M_DONE)) begin
                    m_st = M_CAP;
                    exp_q.delete();
                    m_wrapped = 1'b0;
                    m_trig = 1'b0;
                    m_mode = (mode == 2'd3) ? 0 : int'(mode);
                    m_post = int'(post_cnt);
                    m_tpc = trig_pc;
                end else if (ret_valid && (m_st == M_CAP || m_st == M_POST)) begin
                    exp_q.push_back('{pc: ret_pc, instr: ret_instr, rd: ret_rd,
                                      we: ret_we, wdata: ret_wdata});
                    if (exp_q.size() > DEPTH) begin
                        void'(exp_q.pop_front());
                        m_wrapped = 1'b1;
                    end
                    if (m_st == M_CAP) begin
                        if (m_mode == 1 && exp_q.size() == DEPTH) begin
                            m_st = M_DONE;
                        end else if (m_mode == 2 && ret_pc == m_tpc) begin
                            m_trig = 1'b1;
                            m_left = m_post;
                            m_st = (m_post == 0) ? M_DONE : M_POST;
                        end
                    end else begin
                        m_left--;
                        if (m_left == 0) m_st = M_DONE;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("count", 32'(count_o), 32'(exp_q.size()));
            check("wrapped", 32'(wrapped_o), 32'(m_wrapped));
            check("triggered", 32'(triggered_o), 32'(m_trig));
            check("done", 32'(done_o), 32'(m_st == M_DONE));
            check("rd_valid", 32'(rd_valid_o), 32'(exp_rdv));
            if (exp_rdv) begin
                check("rd_pc", rd_pc_o, exp_rd.pc);
                check("rd_instr", rd_instr_o, exp_rd.instr);
                check("rd_rd", 32'(rd_rd_o), 32'(exp_rd.rd));
                check("rd_we", 32'(rd_we_o), 32'(exp_rd.we));
                check("rd_wdata", rd_wdata_o, exp_rd.wdata);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input bit rv, input logic [31:0] pc, input bit rq, input int idx);
        ret_valid = rv;
        ret_pc    = pc;
        ret_instr = {16'h1300, pc[15:0]};
        ret_rd    = pc[6:2];
        ret_we    = pc[2];
        ret_wdata = pc * 3 + 32'd1;
        rd_req    = rq;
        rd_idx    = idx[3:0];
        tick();
        ret_valid = 1'b0;
        rd_req    = 1'b0;
    endtask

    task automatic do_arm(input logic [1:0] m, input logic [3:0] p, input logic [31:0] t);
        arm = 1'b1;
        mode = m;
        post_cnt = p;
        trig_pc = t;
        tick();
        arm = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic retires(input logic [31:0] start_pc, input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, start_pc + 32'(4 * i), 1'b0, 0);
    endtask

    task automatic rd_chk(input string name, input int idx, input logic [31:0] exp_pc);
        cyc(1'b0, 32'd0, 1'b1, idx);
        check({name, "_valid"}, 32'(rd_valid_o), 32'd1);
        check(name, rd_pc_o, exp_pc);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_count", 32'(count_o), 32'd0);
        check("reset_flags", {29'd0, wrapped_o, triggered_o, done_o}, 32'd0);
        check("reset_rd_valid", 32'(rd_valid_o), 32'd0);
        check("reset_rd_data", rd_pc_o | rd_instr_o | rd_wdata_o, 32'd0);
        check("reset_state", 32'(dbg_state_o), 32'(ST_IDLE));
        rst_n = 1'b1;
        tick();

        // Stop-when-full
        do_arm(2'd1, 4'd0, 32'd0);
        retires(32'd0, 15);
        check("s1_not_done_15", 32'(done_o), 32'd0);
        cyc(1'b1, 32'd60, 1'b0, 0);
        check("s1_done_16", 32'(done_o), 32'd1);
        retires(32'd64, 4);
        check("s1_count", 32'(count_o), 32'd16);
        check("s1_wrapped", 32'(wrapped_o), 32'd0);
        rd_chk("s1_rd0", 0, 32'd0);
        rd_chk("s1_rd15", 15, 32'd60);

        // Free-run with wrap, then read-before-write on the slot being overwritten
        do_clear();
        do_arm(2'd0, 4'd0, 32'd0);
        retires(32'd0, 20);
        check("s2_count", 32'(count_o), 32'd16);
        check("s2_wrapped", 32'(wrapped_o), 32'd1);
        check("s2_done", 32'(done_o), 32'd0);
        rd_chk("s2_rd0", 0, 32'd16);
        rd_chk("s2_rd15", 15, 32'd76);
        cyc(1'b1, 32'd80, 1'b1, 0);
        check("s2_rbw_old", rd_pc_o, 32'd16);
        cyc(1'b0, 32'd0, 1'b1, 15);
        check("s2_newest", rd_pc_o, 32'd80);

        // Trigger with post window of 3
        do_clear();
        do_arm(2'd2, 4'd3, 32'h28);
        retires(32'd0, 11);
        check("s3_triggered", 32'(triggered_o), 32'd1);
        check("s3_not_done", 32'(done_o), 32'd0);
        retires(32'h2c, 2);
        check("s3_post_not_done", 32'(done_o), 32'd0);
        cyc(1'b1, 32'h34, 1'b0, 0);
        check("s3_done", 32'(done_o), 32'd1);
        check("s3_count", 32'(count_o), 32'd14);
        rd_chk("s3_trig_entry", 10, 32'h28);
        cyc(1'b1, 32'h38, 1'b0, 0);
        check("s3_ignored", 32'(count_o), 32'd14);

        // Re-arm from DONE: trigger on first retire with post 0
        do_arm(2'd2, 4'd0, 32'h100);
        cyc(1'b1, 32'h100, 1'b0, 0);
        check("s4_done", 32'(done_o), 32'd1);
        check("s4_count", 32'(count_o), 32'd1);
        rd_chk("s4_rd0", 0, 32'h100);

        // Async reset in POST, off the clock edge
        do_arm(2'd2, 4'd5, 32'h8);
        retires(32'd0, 4);
        check("s5_state_post", 32'(dbg_state_o), 32'(ST_POST));
        #2;
        rst_n = 1'b0;
        #1;
        check("s5_count", 32'(count_o), 32'd0);
        check("s5_flags", {29'd0, wrapped_o, triggered_o, done_o}, 32'd0);
        check("s5_state", 32'(dbg_state_o), 32'(ST_IDLE));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        retires(32'h40, 3);
        check("s5_ignored", 32'(count_o), 32'd0);
        check("s5_idle", 32'(dbg_state_o), 32'(ST_IDLE));

        // Out-of-range read, then clear+arm+retire together
        do_arm(2'd1, 4'd0, 32'd0);
        retires(32'h200, 3);
        rd_chk("s6_oob", 5, 32'd0);
        check("s6_oob_data", rd_instr_o | rd_wdata_o | 32'(rd_rd_o) | 32'(rd_we_o), 32'd0);
        rd_chk("s6_rd2", 2, 32'h208);
        clear = 1'b1;
        arm = 1'b1;
        cyc(1'b1, 32'h300, 1'b0, 0);
        clear = 1'b0;
        arm = 1'b0;
        check("s6_count", 32'(count_o), 32'd0);
        check("s6_state", 32'(dbg_state_o), 32'(ST_IDLE));

        // Mode 3 behaves as free-run
        do_arm(2'd3, 4'd0, 32'd0);
        retires(32'h400, 18);
        check("s7_wrapped", 32'(wrapped_o), 32'd1);
        check("s7_done", 32'(done_o), 32'd0);
        rd_chk("s7_rd0", 0, 32'h408);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
